div_fxp_seq: RTL and testbench
==============================

Name: div_fxp_seq

Overview:
Parametrised sequential fixed-point divider, successor to the existing div block. Adds:
- signed/unsigned mode
- remainder output
- saturation with overflow flag
- explicit start/ack handshake, so results are held until consumed

It sits in the navigation datapath wherever Qm.n ratios are needed, such as heading and normalisation, and is shared by one requester at a time.

Parameters:
DATA_WIDTH, 32, total operand/result width in bits (>= 4)
BIN_POS, 16, fractional bits; binary point position (0 <= BIN_POS < DATA_WIDTH)
SIGNED, 1, 1 = two's-complement operands and results, 0 = unsigned

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted on a rising edge where start && ready
num  in  DATA_WIDTH  dividend, fixed point, sampled at accept
denom  in  DATA_WIDTH  divisor, fixed point, sampled at accept
ready  out  1  block can accept start (state IDLE or DONE)
complete  out  1  result valid, held until ack or new accept
ack  in  1  consumer has taken the result
quot  out  DATA_WIDTH  quotient, Q format identical to inputs
rem  out  DATA_WIDTH  remainder of (|num|<<BIN_POS) mod |denom|, carries the sign of num when SIGNED
div_zero  out  1  denom was zero, valid while complete
overflow  out  1  quotient saturated, valid while complete

Behaviour:
- Reset: rst=1 at any edge forces IDLE regardless of state, including mid-CALC; partial result is discarded. After reset: ready=1, complete=0, quot=0, rem=0, div_zero=0, overflow=0.
- States and transitions:
  - IDLE: ready=1, complete=0. start goes to CALC; if denom==0, start goes to DONE instead.
  - CALC: ready=0. Runs N = DATA_WIDTH+BIN_POS iterations, one per cycle, of restoring division on magnitudes. Dividend is |num| zero-extended and shifted left BIN_POS; divisor is |denom|. Iteration counter goes N-1 down to 0; at 0, goes to DONE.
  - DONE: ready=1, complete=1, outputs stable. ack=1 without start goes to IDLE. start=1 accepts a new operation (implicit ack) and goes to CALC or DONE per the denom check; ack is ignored in that cycle.
- start during CALC is ignored; no queueing.
- Latency from the accepting edge:
  - complete rises exactly N+1 edges later for a normal operation.
  - complete rises 1 edge later for denom==0.
- Magnitudes are taken at accept. In SIGNED mode the most negative value has magnitude 2^(DATA_WIDTH-1) and is held in DATA_WIDTH unsigned bits.
- Result sign (SIGNED mode): quotient negative iff sign(num) != sign(denom) and magnitude != 0. Rounding is truncation toward zero.
- Overflow (SIGNED mode):
  - Positive result: overflow if raw magnitude > 2^(DATA_WIDTH-1)-1; saturate quot to max positive.
  - Negative result: overflow if raw magnitude > 2^(DATA_WIDTH-1); saturate quot to min negative.
- Overflow (unsigned mode): overflow if raw magnitude >= 2^DATA_WIDTH; saturate quot to all ones.
- Whenever overflow=1, rem=0.
- Divide by zero: div_zero=1, overflow=0, rem=0.
  - quot = max positive if num >= 0; min negative if num < 0 (SIGNED).
  - quot = all ones in unsigned mode.
- num==0 with denom!=0: quot=0, rem=0, still takes the full N+1 cycles.
- div_zero and overflow are never both 1.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - saturation helper functions max_pos(width), min_neg(width)
  - iteration-count width constant $clog2(DATA_WIDTH+BIN_POS+1)
- One natural sub-module: div_fxp_core, the magnitude-only restoring shift/subtract datapath (load, step, quotient/remainder registers). Sign handling, saturation and FSM stay in div_fxp_seq.

Test Plan:
All cases use DATA_WIDTH=16, BIN_POS=8, SIGNED=1 unless stated.
- Basic: num=0x0600, denom=0x0200, start -> complete rises 25 edges after accept; quot=0x0300, rem=0, flags 0.
- Signs: num=0xFA00 (-6.0), denom=0x0200 -> quot=0xFD00. num=0x0100, denom=0x0300 -> quot=0x0055, rem=0x0100.
- Overflow: num=0x6400 (100.0), denom=0x0080 (0.5) -> quot=0x7FFF, overflow=1. num=0x8000, denom=0xFF00 (-1.0) -> quot=0x7FFF, overflow=1.
- Div by zero: num=0xFE00, denom=0 -> complete 1 edge after accept, quot=0x8000, div_zero=1; result held 5 cycles with ack=0, then ack -> IDLE.
- Handshake and reset:
  - start held in DONE -> new operation accepted without ack.
  - start pulsed during CALC -> ignored.
  - rst asserted at iteration 10 -> next cycle ready=1, complete=0, all outputs 0.
- Unsigned (SIGNED=0): num=0xFF00, denom=0x0100 -> quot=0xFF00; num=0xFF00, denom=0x0080 -> quot=0xFFFF, overflow=1.
- Randomised check against a reference model: 1000 operands with the seeded stimulus style of test_div, compared on quot, rem, div_zero and overflow.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential fixed-point divider:
// FSM states, saturation constants and the iteration-counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation helpers return a wide vector; callers keep the low bits they need.
  localparam int SAT_W = 128;

  function automatic logic [SAT_W-1:0] max_pos(input int width);
    return (128'd1 << (width - 1)) - 128'd1;
  endfunction

  function automatic logic [SAT_W-1:0] min_neg(input int width);
    return 128'd1 << (width - 1);
  endfunction

  function automatic int cnt_width(input int data_width, input int bin_pos);
    return $clog2(data_width + bin_pos + 1);
  endfunction

endpackage

// File: rtl/div_fxp_core.sv
// Magnitude-only restoring divider datapath: one quotient bit per step.
// Next-step values are exposed so the owner can capture the final result on the last step.
module div_fxp_core import div_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          step,
  input  logic [DATA_WIDTH-1:0]         num_mag,
  input  logic [DATA_WIDTH-1:0]         denom_mag,
  output logic [DATA_WIDTH+BIN_POS-1:0] quo_nx,
  output logic [DATA_WIDTH-1:0]         rem_nx
);

  localparam int N = DATA_WIDTH + BIN_POS;

  logic [N-1:0]          dvd_r;
  logic [N-1:0]          quo_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] dsr_r;
  logic [N-1:0]          dvd_ext_s;
  logic [DATA_WIDTH:0]   shift_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic                  qbit_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    dvd_ext_s = '0;
    dvd_ext_s[DATA_WIDTH-1:0] = num_mag;
    dvd_ext_s = dvd_ext_s << BIN_POS;
    shift_s = {rem_r, dvd_r[N-1]};
    if (shift_s >= {1'b0, dsr_r}) begin
      diff_s = shift_s - {1'b0, dsr_r};
      qbit_s = 1'b1;
    end else begin
      diff_s = shift_s;
      qbit_s = 1'b0;
    end
    // Partial remainder stays below the divisor, so the top bit is always clear.
    rem_nx = diff_s[DATA_WIDTH-1:0];
    quo_nx = {quo_r[N-2:0], qbit_s};
  end

  // Datapath registers: load operands, then shift/subtract once per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= '0;
    end else if (load) begin
      dvd_r <= dvd_ext_s;
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= denom_mag;
    end else if (step) begin
      dvd_r <= dvd_r << 1;
      quo_r <= quo_nx;
      rem_r <= rem_nx;
    end
  end

endmodule

// File: rtl/div_fxp_seq.sv
// Sequential Qm.n divider with sign handling, saturation, divide-by-zero
// detection and a start/ack handshake around the restoring core.
module div_fxp_seq import div_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic                  ready,
  output logic                  complete,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int N     = DATA_WIDTH + BIN_POS;
  localparam int CNT_W = cnt_width(DATA_WIDTH, BIN_POS);
  localparam logic [SAT_W-1:0]      MAX_POS_W = max_pos(DATA_WIDTH);
  localparam logic [SAT_W-1:0]      MIN_NEG_W = min_neg(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_POS   = MAX_POS_W[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MIN_NEG   = MIN_NEG_W[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};
  localparam logic [N-1:0]          LIM_POS   = N'(MAX_POS);
  localparam logic [N-1:0]          LIM_NEG   = N'(MIN_NEG);
  localparam logic [N-1:0]          LIM_U     = N'(ALL_ONES);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(N - 1);

  state_t                state_r, state_nx_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  num_neg_r, den_neg_r;
  logic                  accept_s, den_zero_s;
  logic                  num_neg_s, den_neg_s;
  logic [DATA_WIDTH-1:0] num_mag_s, den_mag_s;
  logic [DATA_WIDTH-1:0] dz_quot_s;
  logic [N-1:0]          quo_raw_s;
  logic [DATA_WIDTH-1:0] rem_raw_s;
  logic                  res_neg_s, fin_ovf_s;
  logic [DATA_WIDTH-1:0] fin_quot_s, fin_rem_s;

  // Operand decode: magnitudes and the divide-by-zero result for this request.
  always_comb begin
    accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    den_zero_s = (denom == {DATA_WIDTH{1'b0}});
    num_neg_s  = (SIGNED != 0) && num[DATA_WIDTH-1];
    den_neg_s  = (SIGNED != 0) && denom[DATA_WIDTH-1];
    num_mag_s  = num_neg_s ? ({DATA_WIDTH{1'b0}} - num) : num;
    den_mag_s  = den_neg_s ? ({DATA_WIDTH{1'b0}} - denom) : denom;
    if (SIGNED != 0) begin
      dz_quot_s = num_neg_s ? MIN_NEG : MAX_POS;
    end else begin
      dz_quot_s = ALL_ONES;
    end
  end

  div_fxp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIN_POS    (BIN_POS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_s && !den_zero_s),
    .step      (state_r == CALC),
    .num_mag   (num_mag_s),
    .denom_mag (den_mag_s),
    .quo_nx    (quo_raw_s),
    .rem_nx    (rem_raw_s)
  );

  // Sign restoration and saturation of the core result on its last step.
  always_comb begin
    res_neg_s = num_neg_r ^ den_neg_r;
    if (SIGNED != 0) begin
      fin_ovf_s = res_neg_s ? (quo_raw_s > LIM_NEG) : (quo_raw_s > LIM_POS);
    end else begin
      fin_ovf_s = (quo_raw_s > LIM_U);
    end
    if (fin_ovf_s) begin
      if (SIGNED != 0) begin
        fin_quot_s = res_neg_s ? MIN_NEG : MAX_POS;
      end else begin
        fin_quot_s = ALL_ONES;
      end
      fin_rem_s = {DATA_WIDTH{1'b0}};
    end else begin
      fin_quot_s = res_neg_s ? ({DATA_WIDTH{1'b0}} - quo_raw_s[DATA_WIDTH-1:0])
                             : quo_raw_s[DATA_WIDTH-1:0];
      fin_rem_s  = num_neg_r ? ({DATA_WIDTH{1'b0}} - rem_raw_s) : rem_raw_s;
    end
  end

  // Next-state logic; a start in DONE doubles as the acknowledge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = den_zero_s ? DONE : CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = CALC;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = den_zero_s ? DONE : CALC;
        end else if (ack) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, iteration counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      num_neg_r <= 1'b0;
      den_neg_r <= 1'b0;
      ready     <= 1'b1;
      complete  <= 1'b0;
      quot      <= {DATA_WIDTH{1'b0}};
      rem       <= {DATA_WIDTH{1'b0}};
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      ready    <= (state_nx_s != CALC);
      complete <= (state_nx_s == DONE);
      if (accept_s) begin
        num_neg_r <= num_neg_s;
        den_neg_r <= den_neg_s;
        cnt_r     <= CNT_LAST;
        if (den_zero_s) begin
          quot     <= dz_quot_s;
          rem      <= {DATA_WIDTH{1'b0}};
          div_zero <= 1'b1;
          overflow <= 1'b0;
        end
      end else if (state_r == CALC) begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          quot     <= fin_quot_s;
          rem      <= fin_rem_s;
          div_zero <= 1'b0;
          overflow <= fin_ovf_s;
        end else begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_div_fxp_seq.sv
// Self-checking bench for div_fxp_seq (16-bit, Q8.8): directed cases on a signed
// and an unsigned instance, then random operands against an arithmetic model.
module tb_div_fxp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] num = 16'h0000;
  logic [15:0] denom = 16'h0000;

  logic        s_ready, s_complete, s_dz, s_ov;
  logic [15:0] s_quot, s_rem;
  logic        u_ready, u_complete, u_dz, u_ov;
  logic [15:0] u_quot, u_rem;

  logic        c_ready, c_complete, c_dz, c_ov;
  logic [15:0] c_quot, c_rem;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_fxp_seq #(.DATA_WIDTH(16), .BIN_POS(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start && !sel), .num(num), .denom(denom),
    .ready(s_ready), .complete(s_complete), .ack(ack && !sel),
    .quot(s_quot), .rem(s_rem), .div_zero(s_dz), .overflow(s_ov)
  );

  div_fxp_seq #(.DATA_WIDTH(16), .BIN_POS(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start && sel), .num(num), .denom(denom),
    .ready(u_ready), .complete(u_complete), .ack(ack && sel),
    .quot(u_quot), .rem(u_rem), .div_zero(u_dz), .overflow(u_ov)
  );

  assign c_ready    = sel ? u_ready    : s_ready;
  assign c_complete = sel ? u_complete : s_complete;
  assign c_quot     = sel ? u_quot     : s_quot;
  assign c_rem      = sel ? u_rem      : s_rem;
  assign c_dz       = sel ? u_dz       : s_dz;
  assign c_ov       = sel ? u_ov       : s_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accepting edge (inclusive) until complete is seen.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (c_complete !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] n, input logic [15:0] d, output int lat);
    num = n;
    denom = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Reference: plain integer division of |num|*2^8 by |denom|, then the sign,
  // truncation and saturation rules applied to the integer result.
  task automatic model(input bit sgn, input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    longint mn, md, raw, rr, lim;
    bit nn, dn, neg;
    nn = sgn && n[15];
    dn = sgn && d[15];
    mn = nn ? (64'd65536 - longint'(n)) : longint'(n);
    md = dn ? (64'd65536 - longint'(d)) : longint'(d);
    if (md == 64'd0) begin
      dz = 1'b1;
      ov = 1'b0;
      r  = 16'h0000;
      q  = sgn ? (nn ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
    end else begin
      dz  = 1'b0;
      raw = (mn * 64'd256) / md;
      rr  = (mn * 64'd256) % md;
      neg = nn ^ dn;
      lim = sgn ? (neg ? 64'd32768 : 64'd32767) : 64'd65535;
      ov  = (raw > lim);
      if (ov) begin
        q = sgn ? (neg ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
        r = 16'h0000;
      end else begin
        q = 16'(neg ? -raw : raw);
        r = 16'(nn ? -rr : rr);
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] n, input logic [15:0] d, input int lat);
    logic [15:0] eq, er;
    logic edz, eov;
    model(!sel, n, d, eq, er, edz, eov);
    chk({tag, "_lat"}, lat, (edz ? 1 : 25));
    chk({tag, "_quot"}, c_quot, eq);
    chk({tag, "_rem"}, c_rem, er);
    chk({tag, "_dz"}, c_dz, edz);
    chk({tag, "_ov"}, c_ov, eov);
  endtask

  initial begin
    int lat;
    logic [15:0] rn, rd;
    int unused_seed;

    unused_seed = $urandom(32'h00D1_5EED);

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_complete", s_complete, 1'b0);
    chk("rst_quot", s_quot, 16'h0000);
    chk("rst_rem", s_rem, 16'h0000);
    chk("rst_flags", {s_dz, s_ov}, 2'b00);
    chk("rst_u_ready", u_ready, 1'b1);

    // Directed signed cases.
    run_op(16'h0600, 16'h0200, lat);
    check_res("basic", 16'h0600, 16'h0200, lat);
    chk("basic_quot_const", c_quot, 16'h0300);
    do_ack();
    chk("ack_idle", {c_ready, c_complete}, 2'b10);

    run_op(16'hFA00, 16'h0200, lat);
    chk("neg_quot", c_quot, 16'hFD00);
    do_ack();
    run_op(16'h0100, 16'h0300, lat);
    chk("third_quot", c_quot, 16'h0055);
    chk("third_rem", c_rem, 16'h0100);
    do_ack();
    run_op(16'h6400, 16'h0080, lat);
    chk("ovf1_quot", c_quot, 16'h7FFF);
    chk("ovf1_flag", c_ov, 1'b1);
    do_ack();
    run_op(16'h8000, 16'hFF00, lat);
    chk("ovf2_quot", c_quot, 16'h7FFF);
    chk("ovf2_flags", {c_ov, c_dz, c_rem}, {1'b1, 1'b0, 16'h0000});
    do_ack();

    // Divide by zero: fast completion, result held until ack.
    run_op(16'hFE00, 16'h0000, lat);
    check_res("dz", 16'hFE00, 16'h0000, lat);
    chk("dz_quot_const", c_quot, 16'h8000);
    for (int i = 0; i < 5; i++) tick();
    chk("dz_hold", {c_complete, c_dz, c_quot}, {1'b1, 1'b1, 16'h8000});
    do_ack();
    chk("dz_ack", {c_ready, c_complete}, 2'b10);

    // start held in DONE: new operation accepted without ack; start in CALC ignored.
    run_op(16'h0600, 16'h0200, lat);
    num = 16'h0100;
    denom = 16'h0300;
    start = 1'b1;
    tick();
    chk("implicit_ack", {c_ready, c_complete}, 2'b00);
    tick();
    tick();
    tick();
    start = 1'b0;
    wait_done(4, lat);
    check_res("held_start", 16'h0100, 16'h0300, lat);
    do_ack();

    num = 16'h0600;
    denom = 16'h0200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    num = 16'h6400;
    denom = 16'h0080;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(7, lat);
    check_res("calc_start_ign", 16'h0600, 16'h0200, lat);
    do_ack();

    // Reset part-way through a calculation.
    run_op(16'h0100, 16'h0300, lat);
    do_ack();
    num = 16'h0600;
    denom = 16'h0200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hs", {s_ready, s_complete}, 2'b10);
    chk("midrst_data", {s_quot, s_rem, s_dz, s_ov}, 34'h0);
    tick();
    chk("midrst_stay", {s_ready, s_complete}, 2'b10);

    // Unsigned instance.
    sel = 1'b1;
    run_op(16'hFF00, 16'h0100, lat);
    check_res("u_basic", 16'hFF00, 16'h0100, lat);
    chk("u_basic_const", c_quot, 16'hFF00);
    do_ack();
    run_op(16'hFF00, 16'h0080, lat);
    chk("u_ovf", {c_quot, c_ov}, {16'hFFFF, 1'b1});
    do_ack();

    // Random operands, signed then unsigned; every fourth result left unacked.
    for (int i = 0; i < 1200; i++) begin
      sel = (i >= 1000);
      rn = 16'($urandom);
      rd = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rd = 16'h0000;
        1: rn = 16'h0000;
        2: rd = 16'($urandom_range(1, 511));
        3: rn = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
        default: ;
      endcase
      run_op(rn, rd, lat);
      check_res(sel ? "u_rand" : "s_rand", rn, rd, lat);
      if ((i % 4) != 3) do_ack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
